cordic_arbiter: RTL and testbench

- Shares one `cordic_top` instance among R requesters.
- Requesters present packed {x,y} operands with a valid/ready handshake.
- The arbiter grants one requester at a time in round-robin order and pulses the CORDIC start.
- It tracks the CORDIC `busy` flag, returns the result on one shared response channel tagged with the requester ID, and flags a hung core via a watchdog.

---
 rtl/cordic_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC core among R requesters in round-robin order,
// returning tagged results and converting a silent or hung core into an error response.
module cordic_arbiter #(
    parameter  int B       = 14,
    parameter  int N       = 7,
    parameter  int R       = 4,
    parameter  int TIMEOUT = 32,
    localparam int W       = 2 * B,
    localparam int IDW     = (R > 1) ? $clog2(R) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req_valid,
    input  logic [R*W-1:0]   req_data,
    output logic [R-1:0]     req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err,
    output logic             cordic_en,
    output logic [W-1:0]     cordic_data_w,
    input  logic             cordic_busy,
    input  logic [W-1:0]     cordic_data_r
);

    // A timeout shorter than the core's own iteration count would fire on healthy operations.
    localparam int WD_LIMIT = (TIMEOUT > N + 2) ? TIMEOUT : N + 3;
    localparam int WDW      = $clog2(WD_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN,
        RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_id;
    logic [WDW-1:0]  r_wd;
    logic [W-1:0]    r_data_w;
    logic [W-1:0]    r_rsp_data;
    logic            r_rsp_err;

    logic            w_grant_found;
    logic [IDW-1:0]  w_grant_idx;
    logic [R-1:0]    w_req_ready;
    logic            w_load;
    logic            w_wd_clr;
    logic            w_wd_inc;
    logic            w_cap_ok;
    logic            w_cap_err;
    logic            w_accept;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        return IDW'((int'(base) + offset) % R);
    endfunction

    // Scanning from the far end lets the nearest valid requester after rr_ptr win.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req_valid[rr_index(r_rr_ptr, k)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = rr_index(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (!rst && r_state == IDLE && w_grant_found) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;
        w_cap_ok     = 1'b0;
        w_cap_err    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_found) begin
                    w_load       = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_wd_clr     = 1'b1;
                w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (cordic_busy) begin
                    w_wd_clr     = 1'b1;
                    w_next_state = RUN;
                end else if (r_wd != '0) begin
                    w_cap_err    = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            RUN: begin
                if (!cordic_busy) begin
                    w_cap_ok     = 1'b1;
                    w_next_state = RESP;
                end else if (r_wd == WDW'(WD_LIMIT - 1)) begin
                    w_cap_err    = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_wd       <= '0;
            r_data_w   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_w <= req_data[int'(w_grant_idx) * W +: W];
                r_id     <= w_grant_idx;
            end
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_cap_ok) begin
                r_rsp_data <= cordic_data_r;
                r_rsp_err  <= 1'b0;
            end else if (w_cap_err) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
            // Rotating on acceptance also moves past a requester whose operation errored.
            if (w_accept) begin
                r_rr_ptr <= (r_id == IDW'(R - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign rsp_valid     = !rst && (r_state == RESP);
    assign cordic_en     = !rst && (r_state == ISSUE);
    assign rsp_id        = r_id;
    assign rsp_data      = r_rsp_data;
    assign rsp_err       = r_rsp_err;
    assign cordic_data_w = r_data_w;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed vectors against a CORDIC stub; a scoreboard monitor
// checks every issued operand and every accepted response in order.
module tb_cordic_arbiter;

    localparam int STUCK_CNT = 100000;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [111:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [27:0]  rsp_data;
    logic         rsp_err;
    logic         cordic_en;
    logic [27:0]  cordic_data_w;
    logic         cordic_busy;
    logic [27:0]  cordic_data_r;

    typedef struct packed {
        logic [1:0]  id;
        logic [27:0] data;
        logic        err;
    } rsp_t;

    rsp_t        expQ[$];
    logic [27:0] opQ[$];
    int          checks = 0;
    int          errors = 0;
    int          outstanding = 0;
    logic [3:0]  hs;

    // Stub core: mode 0 busy for stubK cycles, mode 1 never busy, mode 2 stuck busy.
    int          stubMode = 0;
    int          stubK = 5;
    int          stubCnt;
    bit          stubFixedEn = 1'b0;
    logic [27:0] stubFixed = '0;
    logic [27:0] stubRes;

    cordic_arbiter #(.B(14), .N(7), .R(4), .TIMEOUT(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cordic_en     (cordic_en),
        .cordic_data_w (cordic_data_w),
        .cordic_busy   (cordic_busy),
        .cordic_data_r (cordic_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub result swaps the operand halves, {x,y} -> {y,x}, unless a fixed result is selected.
    always @(posedge clk) begin
        if (rst) begin
            stubCnt <= 0;
            stubRes <= '0;
        end else if (cordic_en) begin
            stubRes <= stubFixedEn ? stubFixed : {cordic_data_w[13:0], cordic_data_w[27:14]};
            stubCnt <= (stubMode == 0) ? stubK : (stubMode == 1) ? 0 : STUCK_CNT;
        end else if (stubCnt != 0 && stubCnt != STUCK_CNT) begin
            stubCnt <= stubCnt - 1;
        end
    end

    assign cordic_busy   = (stubCnt != 0);
    assign cordic_data_r = cordic_busy ? 28'hFFFFFFF : stubRes;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic recordFail(input string name, input string msg);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, msg);
    endtask

    task automatic applyStimulus(input logic [1:0] idx, input logic [27:0] op, input logic [1:0] expId,
                                 input logic [27:0] expData, input logic expErr, input bit expectRsp);
        rsp_t e;
        req_valid[idx] = 1'b1;
        req_data[int'(idx) * 28 +: 28] = op;
        opQ.push_back(op);
        if (expectRsp) begin
            e.id   = expId;
            e.data = expData;
            e.err  = expErr;
            expQ.push_back(e);
        end
    endtask

    // One clock: note handshakes, then the requester drops valid once accepted.
    task automatic step();
        #1;
        hs = req_valid & req_ready;
        @(negedge clk);
        req_valid = req_valid & ~hs;
    endtask

    task automatic waitHs(input logic [1:0] idx, input int bound);
        bit seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            step();
            if (hs[idx]) seen = 1'b1;
        end
        if (!seen) recordFail("wait_handshake", "no handshake within bound");
    endtask

    task automatic waitRspValid(input int bound);
        bit seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            #1;
            if (rsp_valid) seen = 1'b1;
            else step();
        end
        if (!seen) recordFail("wait_rsp_valid", "rsp_valid never rose within bound");
    endtask

    task automatic drainAll(input int bound);
        int n = 0;
        rsp_ready = 1'b1;
        while ((expQ.size() != 0 || opQ.size() != 0 || req_valid != 4'b0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) recordFail("drain", "outstanding work not completed within bound");
    endtask

    // Monitor: operands at each start pulse, responses at each accepted transfer.
    initial begin
        logic [27:0] expOp;
        rsp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                outstanding = 0;
            end else begin
                if (req_ready != 4'b0) checkOutput("grant_while_busy", 32'(outstanding), 32'd0);
                if (cordic_en) begin
                    if (opQ.size() == 0) begin
                        recordFail("unexpected_en", "cordic_en with no operand expected");
                    end else begin
                        expOp = opQ.pop_front();
                        checkOutput("operand", 32'(cordic_data_w), 32'(expOp));
                    end
                    outstanding++;
                end
                if (rsp_valid && rsp_ready) begin
                    if (expQ.size() == 0) begin
                        recordFail("unexpected_rsp", "response with none expected");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                    outstanding--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running, required $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset with every requester already waiting; grants 0,1,2,3 then 0 again.
        applyStimulus(2'd0, {14'd1, 14'd2},       2'd0, {14'd2, 14'd1},       1'b0, 1'b1);
        applyStimulus(2'd1, {14'd100, 14'd200},   2'd1, {14'd200, 14'd100},   1'b0, 1'b1);
        applyStimulus(2'd2, {14'd16383, 14'd0},   2'd2, {14'd0, 14'd16383},   1'b0, 1'b1);
        applyStimulus(2'd3, {14'd4660, 14'd9029}, 2'd3, {14'd9029, 14'd4660}, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_cordic_en", 32'(cordic_en), 32'd0);
        checkOutput("rst_data_w", 32'(cordic_data_w), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rr_first_grant", 32'(req_ready), 32'(4'b0001));
        waitHs(2'd0, 10);
        applyStimulus(2'd0, {14'd7, 14'd8191}, 2'd0, {14'd8191, 14'd7}, 1'b0, 1'b1);
        drainAll(200);

        // Single request with a fixed 8-cycle core and result 28'hABCDE.
        stubK       = 8;
        stubFixedEn = 1'b1;
        stubFixed   = 28'hABCDE;
        applyStimulus(2'd1, {14'd1000, 14'd0}, 2'd1, 28'hABCDE, 1'b0, 1'b1);
        #1;
        checkOutput("t1_ready_t", 32'(req_ready), 32'(4'b0010));
        checkOutput("t1_en_t", 32'(cordic_en), 32'd0);
        step();
        #1;
        checkOutput("t1_en_t1", 32'(cordic_en), 32'd1);
        checkOutput("t1_ready_t1", 32'(req_ready), 32'd0);
        for (int i = 2; i <= 10; i++) begin
            step();
            #1;
            checkOutput("t1_quiet", 32'({cordic_en, rsp_valid, req_ready}), 32'd0);
        end
        step();
        #1;
        checkOutput("t1_valid_t11", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'd1}));
        step();
        #1;
        checkOutput("t1_released", 32'(rsp_valid), 32'd0);
        stubFixedEn = 1'b0;
        stubK       = 5;
        drainAll(50);

        // Pointer skip: serve 2, then with 0 and 3 waiting, 3 must come first.
        applyStimulus(2'd2, {14'd5, 14'd6}, 2'd2, {14'd6, 14'd5}, 1'b0, 1'b1);
        drainAll(50);
        applyStimulus(2'd3, {14'd900, 14'd901}, 2'd3, {14'd901, 14'd900}, 1'b0, 1'b1);
        applyStimulus(2'd0, {14'd42, 14'd43},   2'd0, {14'd43, 14'd42},   1'b0, 1'b1);
        #1;
        checkOutput("skip_grant", 32'(req_ready), 32'(4'b1000));
        drainAll(100);

        // Backpressure: response held for 5 cycles while requester 2 waits.
        rsp_ready = 1'b0;
        stubK     = 3;
        applyStimulus(2'd1, {14'd300, 14'd77}, 2'd1, {14'd77, 14'd300}, 1'b0, 1'b1);
        waitRspValid(50);
        applyStimulus(2'd2, {14'd8000, 14'd1}, 2'd2, {14'd1, 14'd8000}, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_valid", 32'({rsp_valid, rsp_id, rsp_err}), 32'({1'b1, 2'd1, 1'b0}));
            checkOutput("bp_data", 32'(rsp_data), 32'({14'd77, 14'd300}));
            checkOutput("bp_no_grant", 32'({req_ready, cordic_en}), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_release_grant", 32'(req_ready), 32'(4'b0100));
        drainAll(50);

        // Watchdog: core never raises busy; error two cycles into WAIT_BUSY.
        stubMode = 1;
        applyStimulus(2'd3, {14'd9, 14'd10}, 2'd3, 28'd0, 1'b1, 1'b1);
        #1;
        checkOutput("wd0_grant", 32'(req_ready), 32'(4'b1000));
        step();
        step();
        step();
        #1;
        checkOutput("wd0_not_yet", 32'(rsp_valid), 32'd0);
        step();
        #1;
        checkOutput("wd0_err", 32'({rsp_valid, rsp_err}), 32'(2'b11));
        checkOutput("wd0_data", 32'(rsp_data), 32'd0);
        drainAll(20);
        stubMode = 0;
        applyStimulus(2'd0, {14'd55, 14'd66}, 2'd0, {14'd66, 14'd55}, 1'b0, 1'b1);
        drainAll(50);

        // Watchdog: busy stuck high; error after 32 busy cycles in RUN.
        stubMode = 2;
        applyStimulus(2'd1, {14'd11, 14'd22}, 2'd1, 28'd0, 1'b1, 1'b1);
        #1;
        checkOutput("wd1_grant", 32'(req_ready), 32'(4'b0010));
        for (int i = 1; i <= 34; i++) step();
        #1;
        checkOutput("wd1_not_yet", 32'(rsp_valid), 32'd0);
        step();
        #1;
        checkOutput("wd1_err", 32'({rsp_valid, rsp_err}), 32'(2'b11));
        drainAll(20);
        stubMode = 0;
        applyStimulus(2'd2, {14'd123, 14'd4567}, 2'd2, {14'd4567, 14'd123}, 1'b0, 1'b1);
        drainAll(50);

        // Reset during RUN: operation abandoned, pointer back to 0.
        stubK = 10;
        applyStimulus(2'd3, {14'd3000, 14'd3001}, 2'd3, 28'd0, 1'b0, 1'b0);
        #1;
        checkOutput("mr_grant", 32'(req_ready), 32'(4'b1000));
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("mr_req_ready", 32'(req_ready), 32'd0);
        checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mr_cordic_en", 32'(cordic_en), 32'd0);
        checkOutput("mr_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("mr_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("mr_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("mr_data_w", 32'(cordic_data_w), 32'd0);
        applyStimulus(2'd0, {14'd10, 14'd20}, 2'd0, {14'd20, 14'd10}, 1'b0, 1'b1);
        applyStimulus(2'd3, {14'd30, 14'd40}, 2'd3, {14'd40, 14'd30}, 1'b0, 1'b1);
        #1;
        checkOutput("mr_first_grant", 32'(req_ready), 32'(4'b0001));
        drainAll(100);

        step();
        step();
        checkOutput("expq_empty", 32'(expQ.size()), 32'd0);
        checkOutput("opq_empty", 32'(opQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
